// File: rtl/gate_sweep_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gate_sweep_checker                                              |
// | Brief    : Sweeps all 2^N_IN vectors into a gate bank, holds each vector   |
// |            for SETTLE cycles and checks dut_out against a packed truth     |
// |            table. Reports err_count, pass and done. Optional macro          |
// |            ERROR_LOG_EN adds fail_vec/fail_got capture of the first miss.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module gate_sweep_checker #(
  parameter int N_IN   = 2,
  parameter int N_OUT  = 5,
  parameter int SETTLE = 1,
  parameter logic [(N_OUT<<N_IN)-1:0] EXPECT = 20'h66F43
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic [N_IN-1:0]  vec,
  input  logic [N_OUT-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_IN:0]    err_count
`ifdef ERROR_LOG_EN
  ,
  output logic [N_IN-1:0]  fail_vec,
  output logic [N_OUT-1:0] fail_got
`endif
);

  localparam int SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
  localparam int CNT_W      = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_EFF - 1);
  localparam logic [N_IN-1:0]  LAST_VEC    = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic [N_IN:0]    err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [N_OUT-1:0] exp_slice;
  logic             mismatch;

`ifdef ERROR_LOG_EN
  logic [N_IN-1:0]  fail_vec_q, fail_vec_d;
  logic [N_OUT-1:0] fail_got_q, fail_got_d;
`endif

  assign exp_slice = EXPECT[N_OUT*int'(vec_q) +: N_OUT];
  assign mismatch  = (dut_out != exp_slice);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
`ifdef ERROR_LOG_EN
    fail_vec_d = fail_vec_q;
    fail_got_d = fail_got_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
          vec_d   = '0;
          err_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
`ifdef ERROR_LOG_EN
          fail_vec_d = '0;
          fail_got_d = '0;
`endif
        end
      end
      ST_DRIVE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_CHECK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CHECK: begin
        if (mismatch) begin
          err_d = err_q + (N_IN+1)'(1);
`ifdef ERROR_LOG_EN
          // Only the first miss of a sweep is logged.
          if (err_q == '0) begin
            fail_vec_d = vec_q;
            fail_got_d = dut_out;
          end
`endif
        end
        // Terminal vector found by compare so vec never wraps.
        if (vec_q == LAST_VEC) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          state_d = ST_DRIVE;
          vec_d   = vec_q + N_IN'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
`ifdef ERROR_LOG_EN
      fail_vec_q <= '0;
      fail_got_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
`ifdef ERROR_LOG_EN
      fail_vec_q <= fail_vec_d;
      fail_got_q <= fail_got_d;
`endif
    end
  end

  assign vec       = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
`ifdef ERROR_LOG_EN
  assign fail_vec  = fail_vec_q;
  assign fail_got  = fail_got_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gate_sweep_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_gate_sweep_checker                                           |
// | Brief    : Directed bench for gate_sweep_checker with a modelled gate bank. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_gate_sweep_checker;

  logic       clock = 1'b0;
  logic       reset, start, start3, fault;
  logic [1:0] vec, vec3;
  logic [4:0] dut_out, dut_out3;
  logic       busy, done, pass, busy3, done3, pass3;
  logic [2:0] err_count, err_count3;
`ifdef ERROR_LOG_EN
  logic [1:0] fail_vec, fail_vec3;
  logic [4:0] fail_got, fail_got3;
`endif

  always #5 clock = ~clock;

  // Bank outputs {Xor,Or,And,Nand,Not}; fault routes And into the Or bit.
  function automatic logic [4:0] gates(input logic [1:0] v, input logic f);
    logic a, b;
    a = v[0];
    b = v[1];
    return {a ^ b, f ? (a & b) : (a | b), a & b, ~(a & b), ~a};
  endfunction

  assign dut_out  = gates(vec, fault);
  assign dut_out3 = gates(vec3, 1'b0);

  gate_sweep_checker u_dut (
    .clock(clock), .reset(reset), .start(start), .vec(vec), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count)
`ifdef ERROR_LOG_EN
    , .fail_vec(fail_vec), .fail_got(fail_got)
`endif
  );

  gate_sweep_checker #(.SETTLE(3)) u_dut3 (
    .clock(clock), .reset(reset), .start(start3), .vec(vec3), .dut_out(dut_out3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err_count3)
`ifdef ERROR_LOG_EN
    , .fail_vec(fail_vec3), .fail_got(fail_got3)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic       s;
    logic       f;
    logic [1:0] v;
    logic       b;
    logic       d;
    logic       p;
    logic [2:0] e;
  } row_t;

  row_t tbl[$];

  task automatic add(input logic s, input logic f, input logic [1:0] v,
                     input logic b, input logic d, input logic p, input logic [2:0] e);
    row_t r;
    r.s = s; r.f = f; r.v = v; r.b = b; r.d = d; r.p = p; r.e = e;
    tbl.push_back(r);
  endtask

  initial begin
    int cyc;

    // Golden sweep, then a held-done cycle.
    add(1,0,0,1,0,0,0); add(0,0,0,1,0,0,0); add(0,0,1,1,0,0,0); add(0,0,1,1,0,0,0);
    add(0,0,2,1,0,0,0); add(0,0,2,1,0,0,0); add(0,0,3,1,0,0,0); add(0,0,3,1,0,0,0);
    add(0,0,3,0,1,1,0); add(0,0,3,0,1,1,0);
    // Faulty sweep started from DONE, with starts at edges 2 and 5 ignored.
    add(1,1,0,1,0,0,0); add(0,1,0,1,0,0,0); add(1,1,1,1,0,0,0); add(0,1,1,1,0,0,0);
    add(0,1,2,1,0,0,1); add(1,1,2,1,0,0,1); add(0,1,3,1,0,0,2); add(0,1,3,1,0,0,2);
    add(0,1,3,0,1,0,2);
    // Restart clears err_count; start held into DONE restarts at once.
    add(1,0,0,1,0,0,0); add(0,0,0,1,0,0,0); add(0,0,1,1,0,0,0); add(0,0,1,1,0,0,0);
    add(0,0,2,1,0,0,0); add(0,0,2,1,0,0,0); add(0,0,3,1,0,0,0); add(0,0,3,1,0,0,0);
    add(1,0,3,0,1,1,0); add(1,0,0,1,0,0,0); add(0,0,0,1,0,0,0);

    reset  = 1'b1;
    start  = 1'b0;
    start3 = 1'b0;
    fault  = 1'b0;
    tick();
    tick();
    chk("rst vec",  32'(vec), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst pass", 32'(pass), 0);
    chk("rst err",  32'(err_count), 0);
    chk("rst busy3", 32'(busy3), 0);
`ifdef ERROR_LOG_EN
    chk("rst fail_vec", 32'(fail_vec), 0);
    chk("rst fail_got", 32'(fail_got), 0);
`endif
    reset = 1'b0;

    foreach (tbl[i]) begin
      start = tbl[i].s;
      fault = tbl[i].f;
      tick();
      chk($sformatf("row%0d vec", i),  32'(vec),       32'(tbl[i].v));
      chk($sformatf("row%0d busy", i), 32'(busy),      32'(tbl[i].b));
      chk($sformatf("row%0d done", i), 32'(done),      32'(tbl[i].d));
      chk($sformatf("row%0d pass", i), 32'(pass),      32'(tbl[i].p));
      chk($sformatf("row%0d err", i),  32'(err_count), 32'(tbl[i].e));
`ifdef ERROR_LOG_EN
      if (i == 18) begin
        chk("fail_vec", 32'(fail_vec), 1);
        chk("fail_got", 32'(fail_got), 32'h12);
      end
`endif
    end
    start = 1'b0;

    // Reset mid-sweep at vec=2 with one error already counted.
    fault = 1'b1;
    tick();
    tick();
    tick();
    chk("mid vec", 32'(vec), 2);
    chk("mid err", 32'(err_count), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort busy", 32'(busy), 0);
    chk("abort vec",  32'(vec), 0);
    chk("abort err",  32'(err_count), 0);
    chk("abort done", 32'(done), 0);
    tick();
    tick();
    chk("idle done", 32'(done), 0);
    chk("idle busy", 32'(busy), 0);

    fault = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("resweep done edge", 32'(cyc), 8);
    chk("resweep pass", 32'(pass), 1);
    chk("resweep err",  32'(err_count), 0);

    // SETTLE=3: each vector present for four cycles, done at edge 16.
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("s3 vec e%0d", k),  32'(vec3),  32'(k / 4));
      chk($sformatf("s3 done e%0d", k), 32'(done3), 0);
      tick();
    end
    chk("s3 done",  32'(done3), 1);
    chk("s3 busy",  32'(busy3), 0);
    chk("s3 pass",  32'(pass3), 1);
    chk("s3 err",   32'(err_count3), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
